// File: rtl/conv_pe_pipe_pkg.sv
// rtl/conv_pe_pipe_pkg.sv - shared default widths and clog2 helper for the conv PE pipe
package conv_pe_pipe_pkg;

    localparam int DEF_TAPS   = 9;
    localparam int DEF_XW     = 36;
    localparam int DEF_WW     = 16;
    localparam int DEF_ZW     = 36;
    localparam int DEF_MAX_CH = 64;

    // Ceiling log2; clog2(1) = 0 so a single tap or single channel adds no growth bits
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/conv_pe_pipe_dot_tree.sv
// rtl/conv_pe_pipe_dot_tree.sv - registered TAPS-wide multiply stage followed by a registered adder tree
module pe_dot_tree
    import conv_pe_pipe_pkg::*;
#(
    parameter int TAPS = DEF_TAPS,
    parameter int XW   = DEF_XW,
    parameter int WW   = DEF_WW
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic                                   in_valid,
    input  logic                                   in_last,
    input  logic [TAPS*XW-1:0]                     x,
    input  logic [TAPS*WW-1:0]                     w,
    output logic                                   sum_valid,
    output logic                                   sum_last,
    output logic signed [XW+WW+clog2(TAPS)-1:0]    sum
);

    localparam int PRW = XW + WW;
    localparam int PW  = PRW + clog2(TAPS);

    logic signed [PRW-1:0] prod_q [TAPS];
    logic                  s1_valid;
    logic                  s1_last;

    // Stage 1: full-precision products per tap, advancing only when the pipe is enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                prod_q[i] <= '0;
            end
        end else if (en) begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            for (int i = 0; i < TAPS; i++) begin
                prod_q[i] <= PRW'($signed(x[XW*i +: XW])) * PRW'($signed(w[WW*i +: WW]));
            end
        end
    end

    // Heap-ordered binary tree: nodes TAPS-1..2*TAPS-2 are leaves, node n sums 2n+1 and 2n+2.
    // This shape covers any tap count, odd or even, and keeps full width at every node.
    for (genvar n = 0; n < 2*TAPS-1; n++) begin : g_node
        logic signed [PW-1:0] v;
        if (n >= TAPS-1) begin : g_leaf
            assign v = PW'(prod_q[n-(TAPS-1)]);
        end else begin : g_add
            assign v = g_node[2*n+1].v + g_node[2*n+2].v;
        end
    end

    // Stage 2: register the tree root alongside the beat flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_valid <= 1'b0;
            sum_last  <= 1'b0;
            sum       <= '0;
        end else if (en) begin
            sum_valid <= s1_valid;
            sum_last  <= s1_last;
            sum       <= g_node[0].v;
        end
    end

endmodule

// File: rtl/conv_pe_pipe.sv
// rtl/conv_pe_pipe.sv - three-stage dot-product PE with channel accumulation and narrowing
module conv_pe_pipe
    import conv_pe_pipe_pkg::*;
#(
    parameter int TAPS   = DEF_TAPS,
    parameter int XW     = DEF_XW,
    parameter int WW     = DEF_WW,
    parameter int ZW     = DEF_ZW,
    parameter int MAX_CH = DEF_MAX_CH,
    parameter int SAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [TAPS*XW-1:0]   X,
    input  logic [TAPS*WW-1:0]   W,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ZW-1:0]        z,
    output logic                 ovf
);

    localparam int PW = XW + WW + clog2(TAPS);
    localparam int AW = PW + clog2(MAX_CH);
    localparam int CW = (clog2(MAX_CH) > 0) ? clog2(MAX_CH) : 1;
    localparam int EW = ((AW > ZW) ? AW : ZW) + 1;

    localparam logic signed [EW-1:0] ZMAX     = (EW'(1) <<< (ZW - 1)) - EW'(1);
    localparam logic signed [EW-1:0] ZMIN     = ~ZMAX;
    localparam logic [CW-1:0]        CNT_LAST = CW'(MAX_CH - 1);

    logic                 adv;
    logic                 s2_valid;
    logic                 s2_last;
    logic signed [PW-1:0] s2_sum;
    logic signed [AW-1:0] acc;
    logic [CW-1:0]        cnt;
    logic                 flush;
    logic signed [AW-1:0] r;
    logic signed [EW-1:0] rx;
    logic                 r_ovf;
    logic [ZW-1:0]        z_next;

    // The whole pipe stalls only when a held result is not being taken
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;
    assign flush    = s2_valid && (s2_last || (cnt == CNT_LAST));

    pe_dot_tree #(
        .TAPS (TAPS),
        .XW   (XW),
        .WW   (WW)
    ) u_dot (
        .clk       (clk),
        .rst       (rst),
        .en        (adv),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .x         (X),
        .w         (W),
        .sum_valid (s2_valid),
        .sum_last  (s2_last),
        .sum       (s2_sum)
    );

    // Running total plus range check; the extra bit in rx lets ZW exceed AW safely
    always_comb begin
        r      = acc + AW'(s2_sum);
        rx     = EW'(r);
        r_ovf  = (rx > ZMAX) || (rx < ZMIN);
        z_next = rx[ZW-1:0];
        if ((SAT != 0) && r_ovf) begin
            z_next = rx[EW-1] ? ZMIN[ZW-1:0] : ZMAX[ZW-1:0];
        end
    end

    // Stage 3: accumulate channels, emit on last beat or when the channel budget is used up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            z         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= flush;
            if (flush) begin
                z   <= z_next;
                ovf <= r_ovf;
                acc <= '0;
                cnt <= '0;
            end else if (s2_valid) begin
                acc <= r;
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv_pe_pipe.sv
// tb/tb_conv_pe_pipe.sv - randomized and directed bench for conv_pe_pipe against an arithmetic model
module tb_conv_pe_pipe;

    localparam int TAPS = 9;
    localparam int XW   = 36;
    localparam int WW   = 16;
    localparam int ZWA  = 36;
    localparam int MCHA = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_last;
    logic [TAPS*XW-1:0] xb;
    logic [TAPS*WW-1:0] wb;
    logic               out_ready_a;
    logic               ready_bc;
    logic               in_ready_a, in_ready_b, in_ready_c;
    logic               out_valid_a, out_valid_b, out_valid_c;
    logic [ZWA-1:0]     z_a;
    logic [15:0]        z_b, z_c;
    logic               ovf_a, ovf_b, ovf_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    conv_pe_pipe u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_last(in_last),
        .X(xb), .W(wb), .out_valid(out_valid_a), .out_ready(out_ready_a), .z(z_a), .ovf(ovf_a)
    );

    conv_pe_pipe #(.ZW(16), .SAT(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_last(in_last),
        .X(xb), .W(wb), .out_valid(out_valid_b), .out_ready(ready_bc), .z(z_b), .ovf(ovf_b)
    );

    conv_pe_pipe #(.ZW(16), .SAT(0), .MAX_CH(4)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .in_last(in_last),
        .X(xb), .W(wb), .out_valid(out_valid_c), .out_ready(ready_bc), .z(z_c), .ovf(ovf_c)
    );

    task automatic check(input string tag, input longint got, input longint want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Reference model for instance A: whole-beat dot products, summed per accumulation
    longint acc_m;
    int     cnt_m;
    longint exp_z[$];
    bit     exp_o[$];
    longint ez, rm, lim;
    bit     eo;

    function automatic longint dot_now();
        longint s = 0;
        for (int i = 0; i < TAPS; i++) begin
            s += longint'($signed(xb[i*XW +: XW])) * longint'($signed(wb[i*WW +: WW]));
        end
        return s;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            acc_m = 0;
            cnt_m = 0;
            exp_z.delete();
            exp_o.delete();
        end else begin
            if (out_valid_a && out_ready_a) begin
                check("a_sb_pending", longint'(exp_z.size() > 0), 1);
                if (exp_z.size() > 0) begin
                    ez = exp_z.pop_front();
                    eo = exp_o.pop_front();
                    check("a_sb_z", $signed(z_a), ez);
                    check("a_sb_ovf", longint'(ovf_a), longint'(eo));
                end
            end
            if (in_valid && in_ready_a) begin
                rm = acc_m + dot_now();
                cnt_m++;
                if (in_last || cnt_m == MCHA) begin
                    lim = longint'(1) <<< (ZWA - 1);
                    if (rm > lim - 1) begin
                        exp_z.push_back(lim - 1);
                        exp_o.push_back(1'b1);
                    end else if (rm < -lim) begin
                        exp_z.push_back(-lim);
                        exp_o.push_back(1'b1);
                    end else begin
                        exp_z.push_back(rm);
                        exp_o.push_back(1'b0);
                    end
                    acc_m = 0;
                    cnt_m = 0;
                end else begin
                    acc_m = rm;
                end
            end
        end
    end

    // All tasks start and end one time unit after a rising edge
    task automatic set_beat(input longint xv, input longint wv, input bit last);
        for (int i = 0; i < TAPS; i++) begin
            xb[i*XW +: XW] = XW'(xv);
            wb[i*WW +: WW] = WW'(wv);
        end
        in_valid = 1'b1;
        in_last  = last;
    endtask

    task automatic send(input longint xv, input longint wv, input bit last);
        int k;
        set_beat(xv, wv, last);
        k = 0;
        @(negedge clk);
        while (!in_ready_a && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) check("send_timeout", longint'(in_ready_a), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int     wcnt [3];
    longint wz   [3];
    longint wo   [3];

    task automatic watch(input int n);
        for (int i = 0; i < 3; i++) begin
            wcnt[i] = 0;
            wz[i]   = 0;
            wo[i]   = 0;
        end
        repeat (n) begin
            @(negedge clk);
            if (out_valid_a) begin wcnt[0]++; wz[0] = $signed(z_a); wo[0] = ovf_a; end
            if (out_valid_b) begin wcnt[1]++; wz[1] = $signed(z_b); wo[1] = ovf_b; end
            if (out_valid_c) begin wcnt[2]++; wz[2] = $signed(z_c); wo[2] = ovf_c; end
        end
        @(posedge clk);
        #1;
    endtask

    longint got_bp [8];
    int     n_bp;
    bit     hs;
    int     lastprob;
    int     sv;
    logic [63:0] t64;
    logic [31:0] t32;

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        xb          = '0;
        wb          = '0;
        out_ready_a = 1'b1;
        ready_bc    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid_a", longint'(out_valid_a), 0);
        check("rst_z_a", $signed(z_a), 0);
        check("rst_ovf_a", longint'(ovf_a), 0);
        check("rst_in_ready_a", longint'(in_ready_a), 1);
        check("rst_out_valid_c", longint'(out_valid_c), 0);
        check("rst_z_b", $signed(z_b), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single beat of ones, three-cycle latency
        send(1, 1, 1);
        check("lat_e1", longint'(out_valid_a), 0);
        @(posedge clk); #1;
        check("lat_e2", longint'(out_valid_a), 0);
        @(posedge clk); #1;
        check("lat_e3", longint'(out_valid_a), 1);
        check("ones_z", $signed(z_a), 9);
        check("ones_ovf", longint'(ovf_a), 0);
        @(posedge clk); #1;

        // two channels
        send(2, 3, 0);
        send(2, 3, 1);
        watch(8);
        check("two_ch_count", wcnt[0], 1);
        check("two_ch_z", wz[0], 108);

        // negative activations
        send(-5, 7, 1);
        watch(8);
        check("neg_count", wcnt[0], 1);
        check("neg_z", wz[0], -315);

        // narrow result: saturate on B, wrap on C
        do_reset();
        send(1000, 1000, 1);
        watch(8);
        check("sat_z", wz[1], 32767);
        check("sat_ovf", wo[1], 1);
        check("wrap_z", wz[2], 21568);
        check("wrap_ovf", wo[2], 1);

        // backpressure with back-to-back last beats
        do_reset();
        out_ready_a = 1'b0;
        n_bp = 0;
        fork
            begin
                for (int k = 1; k <= 4; k++) send(k, 1, 1);
            end
            begin
                int g;
                g = 0;
                while (!out_valid_a && g < 20) begin
                    @(negedge clk);
                    g++;
                end
                check("bp_valid", longint'(out_valid_a), 1);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_hold_z", $signed(z_a), 9);
                    check("bp_hold_valid", longint'(out_valid_a), 1);
                    check("bp_in_ready", longint'(in_ready_a), 0);
                end
                @(posedge clk);
                #1;
                out_ready_a = 1'b1;
                repeat (15) begin
                    @(negedge clk);
                    if (out_valid_a && n_bp < 8) begin
                        got_bp[n_bp] = $signed(z_a);
                        n_bp++;
                    end
                end
            end
        join
        @(posedge clk); #1;
        check("bp_count", longint'(n_bp), 4);
        for (int k = 0; k < 4; k++) check("bp_order", got_bp[k], 9 * (k + 1));

        // reset mid-accumulation
        do_reset();
        send(1, 1, 0);
        send(1, 1, 0);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", longint'(out_valid_a), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_rel_ready", longint'(in_ready_a), 1);
        send(1, 1, 1);
        watch(8);
        check("rst_mid_count", wcnt[0], 1);
        check("rst_mid_z", wz[0], 9);

        // forced flush at MAX_CH=4 on C
        do_reset();
        for (int k = 0; k < 4; k++) send(1, 1, 0);
        watch(8);
        check("flush_count", wcnt[2], 1);
        check("flush_z", wz[2], 36);
        check("flush_ovf", wo[2], 0);
        check("noflush_a", wcnt[0], 0);

        // randomized traffic on A against the model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            hs = in_valid && in_ready_a;
            @(posedge clk);
            #1;
            out_ready_a = ($urandom_range(0, 3) != 0);
            if (!in_valid || hs) begin
                if ($urandom_range(0, 3) != 0) begin
                    lastprob = (cyc < 1500) ? 4 : 100;
                    in_valid = 1'b1;
                    in_last  = ($urandom_range(0, lastprob - 1) == 0);
                    if ($urandom_range(0, 2) == 0) begin
                        for (int i = 0; i < TAPS; i++) begin
                            t64 = {$urandom, $urandom};
                            t32 = $urandom;
                            xb[i*XW +: XW] = t64[XW-1:0];
                            wb[i*WW +: WW] = t32[WW-1:0];
                        end
                    end else begin
                        for (int i = 0; i < TAPS; i++) begin
                            sv = int'($urandom_range(0, 200)) - 100;
                            xb[i*XW +: XW] = XW'(sv);
                            sv = int'($urandom_range(0, 200)) - 100;
                            wb[i*WW +: WW] = WW'(sv);
                        end
                    end
                end else begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end
            end
        end
        in_valid    = 1'b0;
        in_last     = 1'b0;
        out_ready_a = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("sb_drained", longint'(exp_z.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
